// File: rtl/serial_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter
//  Description : Round-robin, packet-granular arbiter sharing a single
//                byte-serial UART TX core between N_REQ requesters. Sequences
//                the TX core start/busy handshake and revokes idle grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_REQ-1:0]     IN_REQ,
    input  logic [8*N_REQ-1:0]   IN_DATA,
    input  logic [N_REQ-1:0]     IN_LAST,
    output logic [N_REQ-1:0]     OUT_ACK,
    output logic [N_REQ-1:0]     OUT_GRANT,
    output logic [7:0]           OUT_TX_DATA,
    output logic                 OUT_TX_START,
    input  logic                 IN_TX_BUSY,
    output logic                 OUT_TIMEOUT
);

    localparam int c_iw = $clog2(N_REQ);
    localparam int c_cw = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_iw-1:0]  c_last_idx = c_iw'(N_REQ - 1);
    localparam logic [c_iw:0]    c_n_req    = (c_iw + 1)'(N_REQ);
    localparam logic [c_cw-1:0]  c_to_last  = c_cw'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] c_one      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_ACC  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_ack;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_timeout;
    logic [c_iw-1:0]  r_last_winner;
    logic             r_last_flag;
    logic [c_cw-1:0]  r_cnt;

    logic             w_found;
    logic [c_iw-1:0]  w_winner;
    logic [c_iw:0]    w_pos;
    logic [7:0]       w_own_data;
    logic             w_own_req;
    logic             w_own_last;

    // Round-robin search: first requesting index after the previous winner, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_winner;
        w_pos    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_pos = {1'b0, r_last_winner} + (c_iw + 1)'(i);
            if (w_pos >= c_n_req) begin
                w_pos = w_pos - c_n_req;
            end
            if (!w_found && IN_REQ[w_pos[c_iw-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_pos[c_iw-1:0];
            end
        end
    end

    // Owner's byte selected through the one-hot grant so no index decode is needed
    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_data = w_own_data | IN_DATA[8*i +: 8];
            end
        end
    end

    assign w_own_req  = |(IN_REQ & r_grant);
    assign w_own_last = |(IN_LAST & r_grant);

    // Arbitration and TX handshake sequencer; all outputs are registered
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_ack         <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_timeout     <= 1'b0;
            r_last_winner <= c_last_idx;
            r_last_flag   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant       <= c_one << w_winner;
                        r_last_winner <= w_winner;
                        r_cnt         <= '0;
                        r_state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_own_req) begin
                        // A pending byte waits out a busy TX core without aging the grant
                        if (!IN_TX_BUSY) begin
                            r_tx_data   <= w_own_data;
                            r_tx_start  <= 1'b1;
                            r_ack       <= r_grant;
                            r_last_flag <= w_own_last;
                            r_cnt       <= '0;
                            r_state     <= S_WAIT_ACC;
                        end
                    end else if (r_cnt == c_to_last) begin
                        r_timeout <= 1'b1;
                        r_grant   <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_ACC: begin
                    if (IN_TX_BUSY) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!IN_TX_BUSY) begin
                        if (r_last_flag) begin
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_ACK      = r_ack;
    assign OUT_GRANT    = r_grant;
    assign OUT_TX_DATA  = r_tx_data;
    assign OUT_TX_START = r_tx_start;
    assign OUT_TIMEOUT  = r_timeout;

endmodule
`default_nettype wire

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Shares one UART transmitter (the byte-serial TX core that drives OUT_SERIAL_TX) between N_REQ byte-stream requesters, e.g. GFX controller debug dump, terminal writer and status reporter. Grants are round-robin and held for a whole packet, ending at the LAST byte or on an idle timeout. The block sequences the TX core's start/busy handshake and sits between the requesters and the single TX core in the top-level.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, CLK cycles a granted requester may leave IN_REQ low mid-packet before the grant is revoked (>=2)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
IN_REQ  in  N_REQ  per-requester: byte valid on IN_DATA slice
IN_DATA  in  8*N_REQ  byte from requester i on [8i+7:8i]
IN_LAST  in  N_REQ  byte from requester i is final byte of packet
OUT_ACK  out  N_REQ  one-cycle pulse: byte of requester i consumed
OUT_GRANT  out  N_REQ  one-hot current owner, zero when idle
OUT_TX_DATA  out  8  byte to TX core
OUT_TX_START  out  1  one-cycle start pulse to TX core
IN_TX_BUSY  in  1  TX core busy; rises the cycle after START, falls when stop bit completes
OUT_TIMEOUT  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; round-robin pointer last_winner = N_REQ-1; timeout counter 0.
- States: IDLE, SEND, WAIT_ACC, WAIT_DONE.
- IDLE: if any IN_REQ bit is 1, select first requester set, searching from (last_winner+1) mod N_REQ upward with wrap; register OUT_GRANT one-hot, last_winner = winner; -> SEND. Grant is visible the cycle after the request is sampled.
- SEND (owner g): if IN_REQ[g]=1 and IN_TX_BUSY=0, then in that cycle: OUT_TX_DATA <= IN_DATA[g], OUT_TX_START=1, OUT_ACK[g]=1 (both single-cycle registered pulses), latch last_flag = IN_LAST[g], clear timeout counter; -> WAIT_ACC. If IN_REQ[g]=0: increment counter; when counter reaches TIMEOUT_CYCLES-1: OUT_TIMEOUT pulse, OUT_GRANT <= 0, counter 0, -> IDLE.
- WAIT_ACC: wait for IN_TX_BUSY=1 -> WAIT_DONE. OUT_TX_DATA holds.
- WAIT_DONE: wait for IN_TX_BUSY=0; then if last_flag: OUT_GRANT <= 0, -> IDLE; else -> SEND.
- Earliest throughput: IDLE request at cycle 0 -> grant at 1 -> START/ACK at 2.
- Requests from non-owners are ignored while granted; no preemption.
- Request toggling by non-owners never affects OUT_ACK; at most one ACK bit is set in any cycle; OUT_ACK and OUT_TX_START always coincide.
- Single requester may re-win immediately after releasing if no other requester is active (pointer search wraps back to it).
- IN_LAST sampled only on the accepted byte; IN_LAST with IN_REQ=0 ignored.
- Timeout counter counts only in SEND with IN_REQ[g]=0; not during WAIT_ACC/WAIT_DONE.
- Reset asserted mid-byte: outputs drop to 0 immediately; the TX core's in-flight frame is its own concern; the arbiter restarts in IDLE.

Test Plan:
- Reset: assert RESET during WAIT_DONE -> OUT_GRANT=0, OUT_TX_START=0, OUT_ACK=0 immediately; after release, REQ[2]=1 alone -> OUT_GRANT=4'b0100 one cycle later.
- Single packet: requester 1 sends 0x41,0x42,0x43 (LAST on 0x43), TX model busy 10 cycles -> three START pulses with data 0x41/0x42/0x43 in order, three ACK[1] pulses, grant released after third busy falls.
- Round-robin: IN_REQ=4'b1111 continuously, each sending 1-byte packets (LAST=1) -> grant order 0,1,2,3,0; no requester wins twice consecutively.
- No preemption: requester 3 mid 4-byte packet, requester 0 asserts REQ -> requester 0 receives no ACK until requester 3's LAST byte completes; then OUT_GRANT=4'b0001.
- Timeout: TIMEOUT_CYCLES=16, requester 2 sends one non-LAST byte then drops REQ -> OUT_TIMEOUT pulses exactly 16 cycles after entering SEND, OUT_GRANT=0 same cycle.
- Busy backpressure: IN_TX_BUSY held 1 when grant arrives -> no START until busy falls; START occurs the first cycle busy=0 with IN_REQ high.
